// File: rtl/x68k_ldr_pkg.sv
// Shared types for the HPS ioctl download -> 16-bit memory loader bridge:
// FIFO word entry, write FSM states and byte-enable codes.
package x68k_ldr_pkg;

  // Word-address field sized for the widest ioctl address (25-bit bytes).
  localparam int LDR_WADDR_W = 24;

  localparam logic [1:0] BE_LO  = 2'b01;
  localparam logic [1:0] BE_HI  = 2'b10;
  localparam logic [1:0] BE_ALL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [LDR_WADDR_W-1:0] addr;
    logic [15:0]            data;
    logic [1:0]             be;
  } ldr_word_t;

  function automatic ldr_word_t make_word(input logic [LDR_WADDR_W-1:0] waddr,
                                          input logic [15:0]            data,
                                          input logic [1:0]             be);
    ldr_word_t w;
    w.addr = waddr;
    w.data = data;
    w.be   = be;
    return w;
  endfunction

endpackage

// File: rtl/ldr_word_fifo.sv
// Small synchronous FIFO of packed loader words; head is read straight from
// the storage flops, occupancy is a registered count.
module ldr_word_fifo
  import x68k_ldr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   push,
  input  ldr_word_t              din,
  input  logic                   pop,
  output ldr_word_t              dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ldr_word_t      mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ioctl_ldr_bridge.sv
// Packs HPS ioctl download bytes into big-endian 16-bit words and writes them
// to memory through a word FIFO and an ack-handshaked write FSM.
//
// state | meaning
// IDLE  | no write outstanding; pops the FIFO head when one is present
// REQ   | ldr_wr held with stable addr/data/be until ack rising edge
// GAP   | one dead cycle after the ack before the next pop
module ioctl_ldr_bridge
  import x68k_ldr_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DEPTH  = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              ldr_aen,
  output logic [ADDR_W-1:0] ldr_addr,
  output logic [15:0]       ldr_wdat,
  output logic [1:0]        ldr_be,
  output logic              ldr_wr,
  input  logic              ldr_ack,
  output logic              ldr_done
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] WAIT_LVL = CW'(DEPTH - 1);

  logic [CW-1:0]     fifo_count;
  logic              fifo_push, fifo_pop, fifo_empty;
  ldr_word_t         push_word, head_word;

  logic              pend_vld, pend_vld_nxt;
  logic [ADDR_W-2:0] pend_addr, pend_addr_nxt;
  logic [7:0]        pend_hi, pend_hi_nxt;
  logic              dl_q, dl_ended, ack_q;
  wr_state_e         state, state_nxt;

  logic [ADDR_W-2:0] wr_waddr;
  logic              byte_ok;
  logic              unused_hi;

  assign wr_waddr   = ioctl_addr[ADDR_W-1:1];
  assign byte_ok    = ioctl_wr & ~ldr_done;
  assign fifo_empty = (fifo_count == '0);
  assign unused_hi  = ^{ioctl_addr >> ADDR_W, head_word.addr >> (ADDR_W - 1)};

  ldr_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (push_word),
    .pop     (fifo_pop),
    .dout    (head_word),
    .count   (fifo_count)
  );

  // Packer: at most one push per cycle; a lone pending high byte is flushed
  // as soon as the download is low and no byte is arriving.
  always_comb begin
    fifo_push     = 1'b0;
    push_word     = '0;
    pend_vld_nxt  = pend_vld;
    pend_addr_nxt = pend_addr;
    pend_hi_nxt   = pend_hi;
    if (byte_ok && !ioctl_addr[0]) begin
      if (pend_vld) begin
        fifo_push = 1'b1;
        push_word = make_word(LDR_WADDR_W'(pend_addr), {pend_hi, 8'h00}, BE_HI);
      end
      pend_vld_nxt  = 1'b1;
      pend_addr_nxt = wr_waddr;
      pend_hi_nxt   = ioctl_dout;
    end else if (byte_ok) begin
      fifo_push = 1'b1;
      if (pend_vld && (pend_addr == wr_waddr)) begin
        push_word    = make_word(LDR_WADDR_W'(wr_waddr), {pend_hi, ioctl_dout}, BE_ALL);
        pend_vld_nxt = 1'b0;
      end else begin
        push_word = make_word(LDR_WADDR_W'(wr_waddr), {8'h00, ioctl_dout}, BE_LO);
      end
    end else if (pend_vld && !ioctl_download) begin
      fifo_push    = 1'b1;
      push_word    = make_word(LDR_WADDR_W'(pend_addr), {pend_hi, 8'h00}, BE_HI);
      pend_vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_hi   <= '0;
      dl_q      <= 1'b0;
      dl_ended  <= 1'b0;
      ack_q     <= 1'b0;
      ldr_done  <= 1'b0;
    end else begin
      pend_vld  <= pend_vld_nxt;
      pend_addr <= pend_addr_nxt;
      pend_hi   <= pend_hi_nxt;
      dl_q      <= ioctl_download;
      ack_q     <= ldr_ack;
      if (ioctl_download && !dl_q) begin
        dl_ended <= 1'b0;
        ldr_done <= 1'b0;
      end else begin
        if (dl_q && !ioctl_download) dl_ended <= 1'b1;
        if (dl_ended && !ioctl_download && !pend_vld && fifo_empty && (state == ST_IDLE))
          ldr_done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    unique case (state)
      ST_IDLE: if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_REQ:  if (ldr_ack && !ack_q) state_nxt = ST_GAP;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ldr_addr <= '0;
      ldr_wdat <= '0;
      ldr_be   <= '0;
    end else begin
      state <= state_nxt;
      if (fifo_pop) begin
        ldr_addr <= {head_word.addr[ADDR_W-2:0], 1'b0};
        ldr_wdat <= head_word.data;
        ldr_be   <= head_word.be;
      end
    end
  end

  assign ldr_wr     = (state == ST_REQ);
  assign ioctl_wait = (fifo_count >= WAIT_LVL);
  assign ldr_aen    = (ioctl_download | pend_vld | ~fifo_empty | (state != ST_IDLE)) & ~ldr_done;

endmodule

// File: tb/tb_ioctl_ldr_bridge.sv
// Scoreboard bench for ioctl_ldr_bridge: a byte-level reference model queues
// expected memory writes, a memory-side monitor acks and checks them.
module tb_ioctl_ldr_bridge;
  localparam int ADDR_W = 20;
  localparam int DEPTH  = 4;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              ldr_aen;
  logic [ADDR_W-1:0] ldr_addr;
  logic [15:0]       ldr_wdat;
  logic [1:0]        ldr_be;
  logic              ldr_wr;
  logic              ldr_ack;
  logic              ldr_done;

  always #5 clk_sys = ~clk_sys;

  ioctl_ldr_bridge #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .ldr_aen        (ldr_aen),
    .ldr_addr       (ldr_addr),
    .ldr_wdat       (ldr_wdat),
    .ldr_be         (ldr_be),
    .ldr_wr         (ldr_wr),
    .ldr_ack        (ldr_ack),
    .ldr_done       (ldr_done)
  );

  typedef struct {
    int unsigned addr;
    logic [15:0] data;
    logic [1:0]  be;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_hold = 0;
  int          writes_seen = 0;
  bit          m_pend = 1'b0;
  int unsigned m_waddr = 0;
  logic [7:0]  m_hi = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int unsigned waddr, input logic [15:0] d, input logic [1:0] be);
    exp_t e;
    e.addr = waddr * 2;
    e.data = d;
    e.be   = be;
    exp_q.push_back(e);
  endtask

  // Reference: bytes pair up into words by word address (wrapped to ADDR_W).
  task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
    int unsigned wa;
    wa = (32'(a) % (32'd1 << ADDR_W)) / 2;
    if (a[0] == 1'b0) begin
      if (m_pend) push_exp(m_waddr, {m_hi, 8'h00}, 2'b10);
      m_pend  = 1'b1;
      m_waddr = wa;
      m_hi    = d;
    end else if (m_pend && m_waddr == wa) begin
      push_exp(wa, {m_hi, d}, 2'b11);
      m_pend = 1'b0;
    end else begin
      push_exp(wa, {8'h00, d}, 2'b01);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit use_model,
                           output int stalls);
    int guard = 0;
    @(negedge clk_sys);
    while (ioctl_wait && guard < 3000) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 3000) begin
      checks++;
      errors++;
      $display("FAIL wait_bound actual=%0d expected<3000", guard);
    end
    stalls     = guard;
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (use_model) model_byte(a, d);
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_download();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    tick(2);
    chk("done_clear_on_start", ldr_done, 1'b0);
    chk("aen_in_download", ldr_aen, 1'b1);
  endtask

  task automatic end_download();
    int guard = 0;
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    if (m_pend) begin
      push_exp(m_waddr, {m_hi, 8'h00}, 2'b10);
      m_pend = 1'b0;
    end
    while (!ldr_done && guard < 2000) begin
      @(negedge clk_sys);
      guard++;
    end
    chk("done_set", ldr_done, 1'b1);
    chk("aen_after_done", ldr_aen, 1'b0);
    chk("exp_drained", exp_q.size(), 0);
  endtask

  // Memory-side monitor: checks each new request, acks after a delay.
  initial begin : monitor
    bit          in_req = 1'b0;
    bit          acking = 1'b0;
    bit          stable_bad = 1'b0;
    int          cnt = 0;
    exp_t        cur;
    logic [ADDR_W-1:0] c_addr;
    logic [15:0] c_dat;
    logic [1:0]  c_be;
    ldr_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        in_req  = 1'b0;
        acking  = 1'b0;
        ldr_ack = 1'b0;
      end else if (acking) begin
        ldr_ack = 1'b0;
        acking  = 1'b0;
        in_req  = 1'b0;
        chk("wr_drop_after_ack", ldr_wr, 1'b0);
      end else if (in_req) begin
        if (ldr_addr !== c_addr || ldr_wdat !== c_dat || ldr_be !== c_be || ldr_wr !== 1'b1)
          stable_bad = 1'b1;
        if (cnt == 0) begin
          chk("req_stable", stable_bad, 1'b0);
          ldr_ack = 1'b1;
          acking  = 1'b1;
        end else begin
          cnt--;
        end
      end else if (ldr_wr) begin
        in_req     = 1'b1;
        stable_bad = 1'b0;
        c_addr     = ldr_addr;
        c_dat      = ldr_wdat;
        c_be       = ldr_be;
        writes_seen++;
        chk("write_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("wr_addr", ldr_addr, cur.addr);
          chk("wr_data", ldr_wdat, cur.data);
          chk("wr_be", ldr_be, cur.be);
        end
        cnt = (ack_hold > 0) ? ack_hold : $urandom_range(0, 4);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    int st;
    int first_stall;
    int seen_before;
    int guard;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    tick(3);
    chk("rst_wr", ldr_wr, 1'b0);
    chk("rst_done", ldr_done, 1'b0);
    chk("rst_aen", ldr_aen, 1'b0);
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_addr", ldr_addr, 0);
    chk("rst_wdat", ldr_wdat, 0);
    chk("rst_be", ldr_be, 0);
    reset_n = 1'b1;
    tick(4);
    chk("idle_no_done", ldr_done, 1'b0);
    chk("idle_no_aen", ldr_aen, 1'b0);

    // Full word 0x1234 at 0.
    start_download();
    send_byte(25'h0, 8'h12, 1'b1, st);
    send_byte(25'h1, 8'h34, 1'b1, st);
    end_download();

    // Lone high byte flushed by download end.
    start_download();
    send_byte(25'h4, 8'hAA, 1'b1, st);
    end_download();

    // Even byte with a different word pending.
    start_download();
    send_byte(25'h2, 8'h5C, 1'b1, st);
    send_byte(25'h6, 8'hC5, 1'b1, st);
    end_download();

    // Backpressure: ack held off, wait must stall the 9th byte.
    ack_hold    = 50;
    first_stall = -1;
    start_download();
    for (int i = 0; i < 16; i++) begin
      send_byte(25'h100 + 25'(i), 8'($urandom()), 1'b1, st);
      if (st > 0 && first_stall < 0) first_stall = i;
    end
    chk("first_stalled_byte", first_stall, 8);
    ack_hold = 0;
    end_download();

    // Bytes after done are dropped.
    seen_before = writes_seen;
    for (int i = 0; i < 3; i++) send_byte(25'h40 + 25'(i), 8'h77, 1'b0, st);
    tick(20);
    chk("no_write_when_done", writes_seen, seen_before);
    chk("done_sticky", ldr_done, 1'b1);
    chk("aen_when_done", ldr_aen, 1'b0);
    start_download();
    end_download();

    // Randomised downloads with wrapping addresses and random ack latency.
    for (int d = 0; d < 6; d++) begin
      logic [24:0] a;
      int n;
      int r;
      start_download();
      a = 25'($urandom());
      n = $urandom_range(8, 24);
      for (int i = 0; i < n; i++) begin
        send_byte(a, 8'($urandom()), 1'b1, st);
        r = $urandom_range(0, 9);
        if (r < 6) a = a + 25'd1;
        else if (r < 8) a = a + 25'd2;
        else a = 25'($urandom());
        tick($urandom_range(0, 2));
      end
      end_download();
    end

    // Reset while a write is outstanding.
    ack_hold = 40;
    start_download();
    send_byte(25'h8, 8'h56, 1'b1, st);
    send_byte(25'h9, 8'h78, 1'b1, st);
    guard = 0;
    while (!ldr_wr && guard < 50) begin
      @(negedge clk_sys);
      guard++;
    end
    chk("req_reached", ldr_wr, 1'b1);
    #2;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("rst_req_wr", ldr_wr, 1'b0);
    chk("rst_req_addr", ldr_addr, 0);
    chk("rst_req_wdat", ldr_wdat, 0);
    chk("rst_req_be", ldr_be, 0);
    chk("rst_req_wait", ioctl_wait, 1'b0);
    chk("rst_req_aen", ldr_aen, 1'b0);
    exp_q.delete();
    m_pend   = 1'b0;
    ack_hold = 0;
    tick(3);
    reset_n     = 1'b1;
    seen_before = writes_seen;
    tick(6);
    chk("no_wr_after_reset", writes_seen, seen_before);
    chk("done_after_reset", ldr_done, 1'b0);
    start_download();
    send_byte(25'hA, 8'h9A, 1'b1, st);
    send_byte(25'hB, 8'hBC, 1'b1, st);
    send_byte(25'h11, 8'hE1, 1'b1, st);
    end_download();
    chk("total_writes_after_reset", writes_seen, seen_before + 2);

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
